bus_reader: RTL and testbench
=============================

// Module: bus_reader
// PURPOSE
//   Receive end of the shared tri-state data bus. Bus drivers (tri_buf
//   instances, one per source) place a word on bus_data and pulse bus_load.
//   bus_reader captures the word on that clock edge into a small FIFO and
//   presents it to the consumer (register file / ALU latch) with a
//   valid/ready handshake. It is the sink that pairs with every bus driver.
// PARAMETERS
//   WIDTH  8  bus / data word width in bits
//   DEPTH  4  FIFO entries; power of two, >= 2
//   CW     $clog2(DEPTH+1)  derived width of count; not for override
// PORTS
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   bus_data   in   WIDTH  shared tri-state bus, sampled only when bus_load=1
//   bus_load   in   1      strobe from the current bus owner: word valid this cycle
//   bus_busy   out  1      back-pressure to bus owner; 1 = FIFO full
//   out_data   out  WIDTH  head-of-FIFO word (first-word fall-through)
//   out_valid  out  1      out_data holds a valid word
//   out_ready  in   1      consumer accepts head word this cycle
//   count      out  CW     number of stored words, 0..DEPTH
//   overflow   out  1      sticky: a bus_load was dropped because FIFO full
//   clr_ovf    in   1      clears overflow (sync, 1 cycle)
// BEHAVIOUR
// - Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0, out_valid=0,
//   bus_busy=0, overflow=0, out_data=0. Storage array is not reset.
//   Reset mid-stream discards all stored words; rst has priority over all inputs.
// - push = bus_load & (~full | pop); pop = out_valid & out_ready.
// - push: mem[wr_ptr] <= bus_data; wr_ptr <= wr_ptr+1 mod DEPTH.
// - pop: rd_ptr <= rd_ptr+1 mod DEPTH.
// - count: +1 on push only, -1 on pop only, unchanged on both or neither.
// - Latency: word captured at edge N is on out_data with out_valid=1 after
//   edge N (visible in cycle N+1); no combinational bus_data->out_data path.
// - out_valid = (count != 0); out_data = mem[rd_ptr] when valid, else 0.
// - full = (count == DEPTH); bus_busy = full (registered-state derived,
//   no combinational dependence on out_ready).
// - Full + bus_load + pop same cycle: push accepted, count stays DEPTH.
// - Full + bus_load, no pop: word dropped, state unchanged, overflow <= 1.
// - Empty + out_ready: no pop, no pointer movement.
// - Empty + bus_load + out_ready: push only; word not bypassed, appears
//   next cycle.
// - overflow: set on drop; cleared by clr_ovf; drop and clr_ovf in same cycle
//   -> overflow = 1 (set wins).
// - bus_data is sampled verbatim; an undriven bus (Z/X) with bus_load=1 is a
//   protocol violation by the bus owner, not handled in this block.
// - Pointer wrap: DEPTH power of two, pointers are $clog2(DEPTH) bits and wrap
//   naturally.
// STRUCTURE
// - Shared include bus_defs.vh: BUS_WIDTH default (8), BUS_FIFO_DEPTH
//   default (4). Common to bus drivers and bus_reader.
// - One sub-module: bus_reader_mem, a DEPTH x WIDTH register array with
//   one write port (we, waddr, wdata) and one async read port (raddr, rdata).
// - Top level holds pointers, count, overflow and handshake logic.
// TESTING
// 1 Reset: hold rst 2 cycles with bus_load=1, bus_data=8'hFF -> count=0,
//   out_valid=0, out_data=0, overflow=0, bus_busy=0.
// 2 Single word: bus_load=1, bus_data=8'hA5 for 1 cycle, out_ready=0 ->
//   next cycle out_valid=1, out_data=8'hA5, count=1; out_ready=1 for
//   1 cycle -> count=0, out_valid=0.
// 3 Fill/overflow: load 8'h01..8'h05 on consecutive cycles, out_ready=0 ->
//   count=4, bus_busy=1 after 4th, 8'h05 dropped, overflow=1; drain yields
//   01,02,03,04 in order.
// 4 Full push+pop: FIFO full with 10,11,12,13; bus_load=1, bus_data=8'h14,
//   out_ready=1 -> count=4, overflow=0, drain yields 11,12,13,14.
// 5 Wrap: stream 12 words 8'h20..8'h2B with out_ready=1 every cycle -> each
//   word appears exactly 1 cycle after load, count<=1, no overflow.
// 6 Reset mid-op: 3 words stored, rst=1 one cycle -> count=0, out_valid=0;
//   next load 8'h77 is the first word read back.

Source files
------------

// File: rtl/bus_reader_pkg.sv
// Common definitions for the bus receive FIFO: default sizing taken from
// the shared bus defines, plus the per-cycle FIFO action decode.
`include "bus_defs.vh"

package bus_reader_pkg;

    localparam int BUS_WIDTH_DEF = `BUS_WIDTH;
    localparam int BUS_DEPTH_DEF = `BUS_FIFO_DEPTH;

    // What the FIFO does on a given clock edge.
    typedef enum logic [1:0] {
        ACT_IDLE = 2'b00,
        ACT_PUSH = 2'b01,
        ACT_POP  = 2'b10,
        ACT_BOTH = 2'b11
    } fifo_act_e;

    // Decode the edge action. A full FIFO still accepts a load when the
    // head word leaves in the same cycle, so the freed slot is reused.
    function automatic fifo_act_e fifo_action(input logic load,
                                              input logic full,
                                              input logic valid,
                                              input logic ready);
        logic pop;
        logic push;
        pop  = valid & ready;
        push = load & (~full | pop);
        return fifo_act_e'({pop, push});
    endfunction

endpackage

// File: rtl/bus_defs.vh
// Shared bus dimensions used by the bus drivers and by bus_reader.
`ifndef BUS_DEFS_VH
`define BUS_DEFS_VH

`define BUS_WIDTH      8
`define BUS_FIFO_DEPTH 4

`endif

// File: rtl/bus_reader_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module bus_reader_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_reader.sv
// Receive end of the shared data bus. Words strobed by bus_load are
// captured into a small first-word-fall-through FIFO and handed to the
// consumer through a valid/ready handshake. Words arriving while full
// (with no simultaneous pop) are dropped and flagged in a sticky overflow.
module bus_reader
    import bus_reader_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH_DEF,
    parameter int DEPTH = BUS_DEPTH_DEF,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             bus_load,
    output logic             bus_busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic [WIDTH-1:0] head_word;
    fifo_act_e        act;

    // Status is derived from registered count only, so bus_busy never
    // depends combinationally on out_ready.
    always_comb begin
        full      = (count_q == DEPTH_C);
        out_valid = (count_q != '0);
        act       = fifo_action(bus_load, full, out_valid, out_ready);
        push      = act[0];
        pop       = act[1];
        drop      = bus_load & ~push;
    end

    // Pointer, occupancy and sticky-overflow state; reset wins over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (act)
                ACT_PUSH: count_q <= count_q + 1'b1;
                ACT_POP:  count_q <= count_q - 1'b1;
                default:  count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    bus_reader_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~rst),
        .waddr (wr_ptr),
        .wdata (bus_data),
        .raddr (rd_ptr),
        .rdata (head_word)
    );

    assign out_data = out_valid ? head_word : '0;
    assign bus_busy = full;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bus_reader.sv
// Scoreboard bench for bus_reader: directed scenarios followed by random
// traffic, checked against a queue-based reference FIFO.
module tb_bus_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] bus_data = '0;
    logic             bus_load = 1'b0;
    logic             bus_busy;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference FIFO contents and flag; exp_q is the scoreboard of words
    // the consumer must receive, in order.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf = 1'b0;
    logic             m_known = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    bus_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_data  (bus_data),
        .bus_load  (bus_load),
        .bus_busy  (bus_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare registered status against the reference model state.
    task automatic check_status();
        int sz;
        sz = m_q.size();
        chk("count", 32'(count), 32'(sz));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("bus_busy", 32'(bus_busy), 32'(sz == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (sz == 0) chk("out_data_idle", 32'(out_data), 32'h0);
        else         chk("out_data_head", 32'(out_data), 32'(m_q[0]));
    endtask

    // One clock of stimulus: check state, drive inputs, advance model to
    // what the next rising edge must produce.
    task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] d,
                        input logic rdy, input logic clr);
        logic p_pop, p_push, p_full;
        @(negedge clk);
        #1;
        if (m_known) check_status();
        rst       = r;
        bus_load  = ld;
        bus_data  = d;
        out_ready = rdy;
        clr_ovf   = clr;
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            p_full = (m_q.size() == DEPTH);
            p_pop  = (m_q.size() != 0) && rdy;
            p_push = ld && (!p_full || p_pop);
            if (p_pop) void'(m_q.pop_front());
            if (p_push) begin
                m_q.push_back(d);
                exp_q.push_back(d);
            end
            if (ld && !p_push) m_ovf = 1'b1;
            else if (clr)      m_ovf = 1'b0;
        end
    endtask

    // Monitor: every accepted head word must match the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("popped_word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset held two cycles while the bus is loading 0xFF.
        step(1, 1, 8'hFF, 0, 0);
        step(1, 1, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        // Single word, then consume it.
        step(0, 1, 8'hA5, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        // Fill past capacity, then drain in order.
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0);
        step(0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);
        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        step(0, 1, 8'h14, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        // Streaming through pointer wrap.
        for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h20 + i), 1, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        // Reset with words stored, then a fresh word.
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h50 + i), 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, 8'h77, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);
        // Drop and clear in the same cycle: set must win.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h60 + i), 0, i == 4);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60),
                 8'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 10));
        end
        // Drain whatever is left, bounded.
        guard = 0;
        while (m_q.size() != 0 && guard < 20) begin
            step(0, 0, 8'h00, 1, 0);
            guard++;
        end
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
